// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and colour-bar palette.
// Imported by the timing generator and the display top.
package vga_pkg;

  localparam logic [9:0] H_DISPLAY = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;

  localparam logic [9:0] V_DISPLAY = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;

  localparam logic [9:0] BAR_WIDTH = 10'd80;

  localparam logic [9:0] H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX = H_TOTAL - 10'd1;
  localparam logic [9:0] V_MAX = V_TOTAL - 10'd1;

  localparam logic [9:0] HS_START = H_DISPLAY + H_FRONT;
  localparam logic [9:0] HS_END   = HS_START + H_SYNC - 10'd1;
  localparam logic [9:0] VS_START = V_DISPLAY + V_FRONT;
  localparam logic [9:0] VS_END   = VS_START + V_SYNC - 10'd1;

  localparam logic [11:0] C_WHITE   = 12'hFFF;
  localparam logic [11:0] C_YELLOW  = 12'hFF0;
  localparam logic [11:0] C_CYAN    = 12'h0FF;
  localparam logic [11:0] C_GREEN   = 12'h0F0;
  localparam logic [11:0] C_MAGENTA = 12'hF0F;
  localparam logic [11:0] C_RED     = 12'hF00;
  localparam logic [11:0] C_BLUE    = 12'h00F;
  localparam logic [11:0] C_BLACK   = 12'h000;

  // Bar colour for a visible column; a compare chain avoids a divider.
  function automatic logic [11:0] bar_colour(input logic [9:0] px);
    logic [11:0] c;
    if (px < BAR_WIDTH)
      c = C_WHITE;
    else if (px < 10'd2 * BAR_WIDTH)
      c = C_YELLOW;
    else if (px < 10'd3 * BAR_WIDTH)
      c = C_CYAN;
    else if (px < 10'd4 * BAR_WIDTH)
      c = C_GREEN;
    else if (px < 10'd5 * BAR_WIDTH)
      c = C_MAGENTA;
    else if (px < 10'd6 * BAR_WIDTH)
      c = C_RED;
    else if (px < 10'd7 * BAR_WIDTH)
      c = C_BLUE;
    else
      c = C_BLACK;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: 100->25 MHz pixel strobe, x/y raster counters and
// the sync / visible-area decode. Outputs are pure decodes of state.
module vga_timing
  import vga_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_video_on,
  output logic       o_p_tick,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);

  logic [1:0] r_div;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       w_tick;
  logic       w_line_end;

  assign w_tick     = (r_div == 2'd3);
  assign w_line_end = w_tick && (r_x == H_MAX);

  // Free-running divide-by-4 for the pixel strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_div <= 2'd0;
    else
      r_div <= r_div + 2'd1;
  end

  // Horizontal pixel counter, one step per pixel strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_x <= 10'd0;
    else if (w_tick)
      r_x <= (r_x == H_MAX) ? 10'd0 : r_x + 10'd1;
  end

  // Vertical line counter, steps when the line wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_y <= 10'd0;
    else if (w_line_end)
      r_y <= (r_y == V_MAX) ? 10'd0 : r_y + 10'd1;
  end

  // Sync pulses and visible-area flag decoded from the counters.
  always_comb begin
    o_hsync    = 1'b1;
    o_vsync    = 1'b1;
    o_video_on = 1'b0;
    if (r_x >= HS_START && r_x <= HS_END)
      o_hsync = 1'b0;
    if (r_y >= VS_START && r_y <= VS_END)
      o_vsync = 1'b0;
    if (r_x < H_DISPLAY && r_y < V_DISPLAY)
      o_video_on = 1'b1;
  end

  assign o_p_tick = w_tick;
  assign o_x      = r_x;
  assign o_y      = r_y;

endmodule

// File: rtl/vga_display_top.sv
// vga_display_top: Basys 3 VGA block, 640x480@60 with an 8-bar
// colour test pattern; raster signals exported for downstream logic.
module vga_display_top
  import vga_pkg::*;
(
  input  logic        clk_100MHz,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y
);

  logic       w_hsync;
  logic       w_vsync;
  logic       w_video_on;
  logic       w_p_tick;
  logic [9:0] w_x;
  logic [9:0] w_y;

  vga_timing u_timing (
    .i_clk      (clk_100MHz),
    .i_rst_n    (reset),
    .o_hsync    (w_hsync),
    .o_vsync    (w_vsync),
    .o_video_on (w_video_on),
    .o_p_tick   (w_p_tick),
    .o_x        (w_x),
    .o_y        (w_y)
  );

  // Bar colour inside the visible area, black during blanking.
  always_comb begin
    rgb = C_BLACK;
    if (w_video_on)
      rgb = bar_colour(w_x);
  end

  assign hsync    = w_hsync;
  assign vsync    = w_vsync;
  assign video_on = w_video_on;
  assign p_tick   = w_p_tick;
  assign x        = w_x;
  assign y        = w_y;

endmodule

// File: tb/tb_vga_display_top.sv
// tb_vga_display_top: directed checks of reset, strobe, line timing,
// colour bars, vsync window, frame wrap and asynchronous reset.
module tb_vga_display_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        video_on;
  logic        p_tick;
  logic [9:0]  x;
  logic [9:0]  y;

  int n_vec = 0;
  int n_bad = 0;

  vga_display_top dut (
    .clk_100MHz (clk),
    .reset      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .video_on   (video_on),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input int wx, input int wy, input int budget,
                         input string tag);
    int n;
    n = 0;
    while (!(x == wx && y == wy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(x == wx && y == wy)) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s timeout observed=%0d,%0d expected=%0d,%0d",
             tag, x, y, wx, wy);
    end
  endtask

  // Called 2 time units after reset release, just after a negedge.
  task automatic release_seq(input string tag);
    int ticks;
    @(negedge clk);
    chk({tag, "_pt_e1"}, p_tick, 0);
    @(negedge clk);
    chk({tag, "_pt_e2"}, p_tick, 0);
    @(negedge clk);
    chk({tag, "_pt_e3"}, p_tick, 1);
    chk({tag, "_x_e3"}, x, 0);
    @(negedge clk);
    chk({tag, "_pt_e4"}, p_tick, 0);
    chk({tag, "_x_e4"}, x, 1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (p_tick) ticks++;
    end
    chk({tag, "_ticks16"}, ticks, 4);
  endtask

  int          px   [8] = '{79, 80, 320, 559, 560, 639, 640, 799};
  logic [11:0] prgb [8] = '{12'hFFF, 12'hFF0, 12'hF0F, 12'h00F,
                            12'h000, 12'h000, 12'h000, 12'h000};
  logic        pvon [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    int ticks;
    int hs_lo;
    int vs_lo;
    int fall_x;
    int rise_x;
    logic prev_hs;

    rst_n = 1'b0;
    #2;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_ptick", p_tick, 0);
    chk("rst_von", video_on, 1);
    chk("rst_rgb", rgb, 12'hFFF);
    #10 rst_n = 1'b1;
    release_seq("rel1");

    for (int i = 0; i < 8; i++) begin
      wait_xy(px[i], 0, 4000, $sformatf("bar_x%0d", px[i]));
      chk($sformatf("rgb_x%0d", px[i]), rgb, prgb[i]);
      chk($sformatf("von_x%0d", px[i]), video_on, pvon[i]);
    end

    wait_xy(0, 1, 4000, "line1");
    chk("y_inc", y, 1);
    ticks   = 0;
    hs_lo   = 0;
    fall_x  = -1;
    rise_x  = -1;
    prev_hs = hsync;
    for (int n = 0; n < 4000; n++) begin
      if (p_tick) ticks++;
      if (p_tick && !hsync) hs_lo++;
      if (prev_hs && !hsync) fall_x = x;
      if (!prev_hs && hsync) rise_x = x;
      prev_hs = hsync;
      @(negedge clk);
      if (x == 0 && y == 2) break;
    end
    chk("line_ticks", ticks, 800);
    chk("hs_low_ticks", hs_lo, 96);
    chk("hs_fall_x", fall_x, 656);
    chk("hs_rise_x", rise_x, 752);
    chk("y_after_line", y, 2);

    force dut.u_timing.r_y = 10'd489;
    #1 release dut.u_timing.r_y;
    chk("y489", y, 489);
    chk("vs_489", vsync, 1);
    chk("von_489", video_on, 0);
    chk("rgb_489", rgb, 12'h000);
    wait_xy(0, 490, 4000, "y490");
    chk("vs_490", vsync, 0);
    chk("von_490", video_on, 0);
    vs_lo = 0;
    for (int n = 0; n < 8000; n++) begin
      if (p_tick && !vsync) vs_lo++;
      @(negedge clk);
      if (vsync) break;
    end
    chk("vs_low_ticks", vs_lo, 1600);
    chk("vs_rise_y", y, 492);
    chk("vs_rise_x", x, 0);

    force dut.u_timing.r_y = 10'd524;
    #1 release dut.u_timing.r_y;
    wait_xy(799, 524, 4000, "xy_max");
    chk("max_hsync", hsync, 1);
    chk("max_vsync", vsync, 1);
    chk("max_von", video_on, 0);
    chk("max_rgb", rgb, 12'h000);
    for (int n = 0; n < 4 && !p_tick; n++) @(negedge clk);
    @(negedge clk);
    chk("wrap_x", x, 0);
    chk("wrap_y", y, 0);
    chk("wrap_von", video_on, 1);
    chk("wrap_rgb", rgb, 12'hFFF);

    force dut.u_timing.r_y = 10'd199;
    #1 release dut.u_timing.r_y;
    wait_xy(100, 200, 4000, "y200");
    chk("pre_rst_x", x, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_ptick", p_tick, 0);
    chk("arst_rgb", rgb, 12'hFFF);
    @(negedge clk);
    #2 rst_n = 1'b1;
    release_seq("rel2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
